// File: rtl/lsu_mw_pkg.sv
// Shared pipeline definitions for the memory stage: func3 access encodings,
// load/store unit state encoding and the natural-alignment lane helper.
package lsu_mw_pkg;

  // func3 access size / sign encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_t;

  // Byte offset of the access inside its word, forced to natural alignment:
  // bytes keep both low bits, halves keep addr[1], words start at lane 0.
  function automatic logic [1:0] lane_off(input logic [2:0] f3, input logic [1:0] a);
    logic [1:0] off;
    case (f3)
      F3_B, F3_BU: off = a;
      F3_H, F3_HU: off = {a[1], 1'b0};
      default:     off = 2'b00;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: moves the addressed byte/half of the bus word down to bit 0
// and sign- or zero-extends it according to func3. Purely combinational.
module lsu_load_fmt
  import lsu_mw_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  func3,
  output logic [31:0] ext_data
);

  logic [31:0] shifted_s;

  // Shift the addressed lane down and extend it to 32 bits
  always_comb begin
    shifted_s = mem_rdata >> {off, 3'b000};
    case (func3)
      F3_B:    ext_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
      F3_BU:   ext_data = {24'h00_0000, shifted_s[7:0]};
      F3_H:    ext_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
      F3_HU:   ext_data = {16'h0000, shifted_s[15:0]};
      F3_W:    ext_data = shifted_s;
      default: ext_data = shifted_s;
    endcase
  end

endmodule

// File: rtl/lsu_mw.sv
// Memory-stage load/store unit: runs one request/ready bus transaction per
// accepted access and stalls the pipeline until it completes.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses are refused and flagged on misalign; when undefined
// the low address bits are forced to natural alignment and misalign is 0.
module lsu_mw
  import lsu_mw_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [2:0]  func3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] load_data_q, load_data_d;

  logic        req_s, legal_s, mis_s, idle_s, accept_s;
  logic [1:0]  off_s;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [31:0] fmt_s;

  // Decode the incoming access: legality, alignment, lanes and store data
  always_comb begin
    req_s = rd_en | wr_en;
    case (func3)
      F3_B, F3_H, F3_W: legal_s = 1'b1;
      F3_BU, F3_HU:     legal_s = ~wr_en;   // unsigned sizes exist for loads only
      default:          legal_s = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    case (func3)
      F3_H, F3_HU: mis_s = addr[0];
      F3_W:        mis_s = (addr[1:0] != 2'b00);
      default:     mis_s = 1'b0;
    endcase
`else
    mis_s = 1'b0;
`endif
    off_s = lane_off(func3, addr[1:0]);
    case (func3)
      F3_B, F3_BU: begin
        be_s = 4'b0001 << off_s;
        wd_s = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be_s = 4'b0011 << off_s;
        wd_s = {2{wdata[15:0]}};
      end
      default: begin
        be_s = 4'b1111;
        wd_s = wdata;
      end
    endcase
    idle_s   = (state_q == ST_IDLE);
    accept_s = idle_s & req_s & legal_s & ~mis_s;
  end

  // Pipeline hold and misalignment flag; both forced low while in reset
  always_comb begin
    stall = ~reset & (accept_s | (state_q == ST_BUSY));
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = ~reset & idle_s & req_s & legal_s & mis_s;
`else
    misalign = 1'b0;
`endif
  end

  lsu_load_fmt u_load_fmt (
    .mem_rdata (mem_rdata),
    .off       (off_q),
    .func3     (func3_q),
    .ext_data  (fmt_s)
  );

  // FSM next state and capture of the bus fields / load result
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    off_d       = off_q;
    func3_d     = func3_q;
    load_data_d = load_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d     = ST_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = wr_en;   // rd_en & wr_en together is a store
          mem_addr_d  = {addr[31:2], 2'b00};
          mem_be_d    = be_s;
          mem_wdata_d = wd_s;
          off_d       = off_s;
          func3_d     = func3;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          state_d   = ST_DONE;
          mem_req_d = 1'b0;
          if (!mem_we_q) begin
            load_data_d = fmt_s;
          end else begin
            load_data_d = load_data_q;
          end
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;   // inputs ignored so the held instruction is not re-issued
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and bus registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0000_0000;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      off_q       <= 2'b00;
      func3_q     <= 3'b000;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      off_q       <= off_d;
      func3_q     <= func3_d;
      load_data_q <= load_data_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign load_data = load_data_q;

endmodule

// File: doc/lsu_mw.md
# lsu_mw

Load/store unit for the memory stage of the pipeline. It consumes the memory-stage control fields latched by the execute-to-memory pipeline register (`rd_en`, `wr_en`, `func3`) together with the effective address and store data. It runs a request/ready transaction on the data-memory bus and returns a formatted, sign- or zero-extended load value to writeback. It stalls the pipeline until the transaction completes.

## Interface
- `clk`  in  1  pipeline clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rd_en`  in  1  memory-stage load request.
- `wr_en`  in  1  memory-stage store request.
- `func3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  32  byte address of the access.
- `wdata`  in  32  store data; right-aligned.
- `stall`  out  1  holds the pipeline while an access is in flight.
- `load_data`  out  32  formatted load result; valid in DONE and held until the next load completes.
- `misalign`  out  1  misaligned-access flag (macro-dependent).
- `mem_req`  out  1  bus request; registered.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  bus completion, sampled while `mem_req`=1.
- `mem_rdata`  in  32  read word, valid with `mem_ready`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - A valid access (`rd_en|wr_en` with a legal `func3`) goes to BUSY.
  - The unit captures `we`, `be`, word address, lane-shifted write data, `addr[1:0]` and `func3` into internal registers.
- BUSY:
  - `mem_req`=1 with the captured fields held stable.
  - `mem_ready`=1 goes to DONE. For a load, the formatted `mem_rdata` is registered into `load_data`.
- DONE: lasts one cycle, then returns to IDLE. Inputs are ignored in DONE, so the still-present instruction is not re-issued.
- `stall` = (IDLE & valid access) | BUSY. `stall` is combinational from the inputs and low in DONE.
- Byte enables:
  - B = `4'b0001 << addr[1:0]`.
  - H = `4'b0011 << {addr[1],1'b0}`.
  - W = `4'b1111`.
- Store data: B replicates `wdata[7:0]` ×4; H replicates `wdata[15:0]` ×2.
- Load format:
  - The addressed byte/half is shifted down to bit 0.
  - B and H sign-extend; BU, HU and W zero-fill as applicable.
- Illegal `func3` (011, 110, 111, or a store with 1xx): no bus access, no stall, `load_data` unchanged.
- `rd_en` and `wr_en` both high: treated as a store.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0, `load_data`=0, `misalign`=0, `stall`=0.
- Minimum latency with a zero-wait bus: accept cycle T, then `mem_req` at T+1 with `mem_ready` at T+1, then DONE at T+2. That is 2 stall cycles.
- Each wait cycle of `mem_ready` adds one stall cycle. `mem_req` never drops before `mem_ready`.
- `mem_ready` while `mem_req`=0 is ignored.
- Reset asserted mid-transaction:
  - Immediate return to reset values and `mem_req` deasserts asynchronously.
  - The pending access is abandoned; the bus must tolerate the dropped request.
- Back-to-back accesses: the earliest issue of the next access is the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - An access with H and `addr[0]`=1, or W and `addr[1:0]`≠0, issues no bus request and does not stall.
  - `misalign` pulses high for that one cycle (combinational) and `load_data` is unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied 0.
  - The low address bits are forced to natural alignment: H uses `addr[1]`, W uses word alignment.
  - The access proceeds normally.

## Structure
- Shared pipeline package holds:
  - the `func3` encodings as localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the `lsu_state_t` enum.
- Sub-module `lsu_load_fmt`: purely combinational. Takes `mem_rdata`, `addr[1:0]` and `func3`, and produces the 32-bit extended value.
- The FSM and store lane logic stay in `lsu_mw`.

## Test plan
- SW `addr`=0x104, `wdata`=0xDEADBEEF, `mem_ready` in the first BUSY cycle → `mem_be`=1111, `mem_addr`=0x104, `mem_wdata`=0xDEADBEEF, `stall` high exactly 2 cycles.
- SB `addr`=0x203, `wdata`=0x000000A5 → `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x200.
- LB `addr`=0x302 with `mem_rdata`=0x0080FF11, then LBU at the same address → `load_data`=0xFFFFFF80, then 0x00000080.
- LH `addr`=0x402, `mem_rdata`=0x8001_7FFF, `mem_ready` delayed 3 cycles → `stall` high 5 cycles, `mem_req` steady, `load_data`=0xFFFF8001.
- `reset` asserted in the second BUSY cycle → `mem_req`=0 and `stall`=0 in the same cycle, `load_data`=0; the next LW completes normally.
- LW `addr`=0x501:
  - with `LSU_MISALIGN_TRAP_EN`: `misalign`=1, no `mem_req`.
  - without it: `mem_addr`=0x500, `mem_be`=1111, `misalign`=0.
